// File: rtl/cgra_pkg.sv
// Shared opcode definitions for the CGRA tile chain.
package cgra_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASS = 3'd0,
        OP_ADD  = 3'd1,
        OP_XOR  = 3'd2,
        OP_ACC  = 3'd3,
        OP_DROP = 3'd4
    } op_e;

    // Unassigned codes fall back to PASS so a bad write cannot wedge a tile.
    function automatic op_e decode_op(input logic [OP_W-1:0] raw);
        case (raw)
            3'd1:    return OP_ADD;
            3'd2:    return OP_XOR;
            3'd3:    return OP_ACC;
            3'd4:    return OP_DROP;
            default: return OP_PASS;
        endcase
    endfunction

endpackage

// File: rtl/cgra_tile.sv
// One chain stage: input FIFO, combinational ALU on its head, cfg and acc registers.
// Define CGRA_SAT_EN to make ADD/ACC saturate instead of wrapping.
module cgra_tile
    import cgra_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    input  logic                  i_cfg_we,
    input  logic [OP_W-1:0]       i_cfg_op,
    input  logic [DATA_WIDTH-1:0] i_cfg_imm
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    op_e                   r_op;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_acc;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_alu;

    function automatic logic [DATA_WIDTH-1:0] add_op(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef CGRA_SAT_EN
        return s[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
`else
        return s[DATA_WIDTH-1:0];
`endif
    endfunction

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    // Push only ever sees the registered full flag: no pop bypass into a full FIFO.
    assign w_push  = i_valid && !w_full;
    assign w_pop   = !w_empty && ((r_op == OP_DROP) || i_ready);
    assign w_head  = r_mem[r_rd_ptr];

    always_comb begin
        w_alu = w_head;
        case (r_op)
            OP_ADD:  w_alu = add_op(w_head, r_imm);
            OP_XOR:  w_alu = w_head ^ r_imm;
            OP_ACC:  w_alu = add_op(r_acc, w_head);
            default: w_alu = w_head;
        endcase
    end

    assign o_ready = !w_full;
    assign o_valid = !w_empty && (r_op != OP_DROP);
    assign o_data  = w_empty ? '0 : w_alu;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A cfg write wins over an ACC update in the same cycle; the popped word
    // still saw the old op/imm/acc through the combinational ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= OP_PASS;
            r_imm <= '0;
            r_acc <= '0;
        end else if (i_cfg_we) begin
            r_op  <= decode_op(i_cfg_op);
            r_imm <= i_cfg_imm;
            r_acc <= '0;
        end else if (w_pop && (r_op == OP_ACC)) begin
            r_acc <= w_alu;
        end
    end

endmodule

// File: rtl/cgra_chain.sv
// Linear chain of NUM_TILES cgra_tile stages with valid/ready ingress and egress.
// Saturating arithmetic is selected per build with CGRA_SAT_EN (see cgra_tile).
module cgra_chain
    import cgra_pkg::*;
#(
    parameter int NUM_TILES  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(NUM_TILES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [OP_W-1:0]       cfg_op,
    input  logic [DATA_WIDTH-1:0] cfg_imm
);

    // Link i feeds tile i; link NUM_TILES is the egress port.
    logic [NUM_TILES:0][DATA_WIDTH-1:0] w_data;
    logic [NUM_TILES:0]                 w_valid;
    logic [NUM_TILES:0]                 w_ready;

    assign w_data[0]          = in_data;
    assign w_valid[0]         = in_valid;
    assign in_ready           = w_ready[0];
    assign out_data           = w_data[NUM_TILES];
    assign out_valid          = w_valid[NUM_TILES];
    assign w_ready[NUM_TILES] = out_ready;

    for (genvar i = 0; i < NUM_TILES; i++) begin : g_tile
        logic w_cfg_we;
        // Addresses beyond NUM_TILES-1 match no tile and are dropped.
        assign w_cfg_we = cfg_we && (cfg_addr == AW'(i));

        cgra_tile #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_tile (
            .clk       (clk),
            .reset     (reset),
            .i_data    (w_data[i]),
            .i_valid   (w_valid[i]),
            .o_ready   (w_ready[i]),
            .o_data    (w_data[i+1]),
            .o_valid   (w_valid[i+1]),
            .i_ready   (w_ready[i+1]),
            .i_cfg_we  (w_cfg_we),
            .i_cfg_op  (cfg_op),
            .i_cfg_imm (cfg_imm)
        );
    end

endmodule

// File: tb/tb_cgra_chain.sv
// Self-checking bench for cgra_chain: directed scenarios plus randomized traffic
// against a queue-based reference model that transforms each word at ingress.
module tb_cgra_chain;

    localparam int NT = 4;
    localparam int DW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = '0;
    logic [2:0]    cfg_op = '0;
    logic [DW-1:0] cfg_imm = '0;

    always #5 clk = ~clk;

    cgra_chain #(.NUM_TILES(NT), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_op    (cfg_op),
        .cfg_imm   (cfg_imm)
    );

    // Reference model state
    int m_op [NT];
    int m_imm[NT];
    int m_acc[NT];
    int exp_q[$];
    int out_log[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int in_cyc = 0;
    int out_cyc = 0;
    int n_out = 0;
    int last_out = 0;
    bit accepted = 0;
    bit hold_pend = 0;
    int hold_data = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int madd(input int a, input int b);
        int s;
        s = a + b;
`ifdef CGRA_SAT_EN
        if (s > 255) return 255;
`endif
        return s % 256;
    endfunction

    // Config only changes while the chain is idle, so each word can be
    // pushed through every tile's rule the moment it is accepted.
    task automatic model_in(input int d);
        int v;
        v = d;
        for (int t = 0; t < NT; t++) begin
            case (m_op[t])
                1: v = madd(v, m_imm[t]);
                2: v = v ^ m_imm[t];
                3: begin m_acc[t] = madd(m_acc[t], v); v = m_acc[t]; end
                4: return;
                default: ;
            endcase
        end
        exp_q.push_back(v);
    endtask

    task automatic model_reset();
        exp_q.delete();
        hold_pend = 0;
        for (int t = 0; t < NT; t++) begin
            m_op[t] = 0; m_imm[t] = 0; m_acc[t] = 0;
        end
    endtask

    // Sample at negedge (what the DUT will see at the next posedge), then advance.
    task automatic tick();
        @(negedge clk);
        cyc++;
        accepted = 0;
        if (reset) begin
            model_reset();
        end else begin
            if (hold_pend && out_valid) chk("hold_stable", out_data, hold_data);
            if (out_valid && out_ready) begin
                n_out++;
                last_out = out_data;
                out_cyc = cyc;
                out_log.push_back(out_data);
                if (exp_q.size() == 0) chk("egress_extra", exp_q.size(), 1);
                else chk("egress", out_data, exp_q.pop_front());
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (in_valid && in_ready) begin
                accepted = 1;
                in_cyc = cyc;
                model_in(in_data);
            end
            if (cfg_we) begin
                m_op[cfg_addr]  = (cfg_op > 3'd4) ? 0 : int'(cfg_op);
                m_imm[cfg_addr] = cfg_imm;
                m_acc[cfg_addr] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Garbage on the inputs during reset must be ignored.
    task automatic do_reset();
        reset = 1; in_valid = 1; in_data = 8'hC3;
        cfg_we = 1; cfg_addr = 0; cfg_op = 3'd1; cfg_imm = 8'h77;
        tick();
        reset = 0; in_valid = 0; cfg_we = 0;
    endtask

    task automatic cfg(input int addr, input int op, input int imm);
        cfg_we = 1; cfg_addr = addr[1:0]; cfg_op = op[2:0]; cfg_imm = imm[7:0];
        tick();
        cfg_we = 0;
    endtask

    task automatic push(input int d);
        bit ok;
        ok = 0;
        in_valid = 1; in_data = d[7:0];
        for (int k = 0; k < 50; k++) begin
            tick();
            if (accepted) begin ok = 1; break; end
        end
        in_valid = 0;
        chk("push_accept", ok, 1);
    endtask

    task automatic drain();
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick();
        chk("drain_empty", exp_q.size(), 0);
        for (int k = 0; k < 6; k++) tick();
        chk("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        int nacc;

        // Reset state
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);

        // All PASS: 0x5A exits 4 cycles after transfer
        out_ready = 1;
        push(8'h5A);
        drain();
        chk("latency", out_cyc - in_cyc, 4);
        chk("pass_data", last_out, 8'h5A);

        // ADD then XOR
        cfg(0, 1, 8'h10);
        cfg(1, 2, 8'hFF);
        push(8'h05);
        drain();
        chk("add_xor", last_out, 8'hEA);

        // Overflow: wrap or saturate
        do_reset();
        cfg(0, 1, 8'hF0);
        push(8'h20);
        drain();
`ifdef CGRA_SAT_EN
        chk("add_ovf", last_out, 8'hFF);
`else
        chk("add_ovf", last_out, 8'h10);
`endif

        // Backpressure fills 16 entries, then release
        do_reset();
        out_ready = 0; n_out = 0; nacc = 0; in_valid = 1;
        for (int k = 0; k < 30; k++) begin
            in_data = nacc[7:0];
            tick();
            if (accepted) nacc++;
        end
        chk("bp_accepted", nacc, 16);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1;
        for (int k = 0; k < 40 && nacc < 17; k++) begin
            in_data = nacc[7:0];
            tick();
            if (accepted) nacc++;
        end
        in_valid = 0;
        chk("bp_last_accepted", nacc, 17);
        drain();
        chk("bp_out_count", n_out, 17);

        // ACC at the last tile, reconfig clears acc, then DROP
        do_reset();
        out_ready = 1;
        cfg(3, 3, 0);
        out_log.delete();
        push(1); push(2); push(3);
        drain();
        chk("acc_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("acc_0", out_log[0], 1);
            chk("acc_1", out_log[1], 3);
            chk("acc_2", out_log[2], 6);
        end
        cfg(3, 3, 0);
        push(4);
        drain();
        chk("acc_cleared", last_out, 4);
        cfg(2, 4, 0);
        n_out = 0;
        push(8'h11); push(8'h22); push(8'h33);
        drain();
        chk("drop_count", n_out, 0);

        // Reset with words in flight
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 8; i++) push(i + 8'h40);
        reset = 1;
        tick();
        reset = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        n_out = 0;
        out_ready = 1;
        push(8'h33);
        drain();
        chk("midrst_count", n_out, 1);
        chk("midrst_data", last_out, 8'h33);

        // Randomized config and traffic
        for (int r = 0; r < 10; r++) begin
            for (int t = 0; t < NT; t++)
                cfg(t, (r < 3 && t == 2) ? 1 : $urandom_range(0, 7), $urandom_range(0, 255));
            for (int k = 0; k < 80; k++) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data = DW'($urandom_range(0, 255));
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cgra_chain.md
CGRA_CHAIN -- requirements
Module: cgra_chain

Interface
REQ-001 Parameter NUM_TILES, default 4; number of tile stages in the chain, minimum 2.
REQ-002 Parameter DATA_WIDTH, default 8; width of data words and immediates.
REQ-003 Parameter FIFO_DEPTH, default 4; entries per tile input FIFO, power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  DATA_WIDTH  ingress word into tile 0.
REQ-007 in_valid / in_ready  input / output  1 / 1  ingress handshake; transfer occurs when both are high.
REQ-008 out_data  output  DATA_WIDTH  egress word from the last tile.
REQ-009 out_valid / out_ready  output / input  1 / 1  egress handshake.
REQ-010 cfg_we  input  1  configuration write strobe.
REQ-011 cfg_addr  input  clog2(NUM_TILES)  target tile; out-of-range writes are ignored.
REQ-012 cfg_op  input  3  tile opcode: PASS=0, ADD=1, XOR=2, ACC=3, DROP=4; codes 5-7 decode as PASS.
REQ-013 cfg_imm  input  DATA_WIDTH  tile immediate.

Function
REQ-014 Each tile SHALL consist of an input FIFO followed by a combinational ALU on the FIFO head; the ALU result feeds the next tile's FIFO, and the last tile's result drives out_data.
REQ-015 A tile SHALL pop its head when the head is valid and either the downstream side accepts it (downstream FIFO not full, or out_ready for the last tile) or the opcode is DROP.
REQ-016 in_ready SHALL equal !full of tile 0; a FIFO SHALL assert full at FIFO_DEPTH entries, with no same-cycle pop bypass.
REQ-017 A simultaneous push and pop SHALL leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 Word order SHALL be preserved end to end; no word SHALL be duplicated or lost except by DROP.
REQ-019 Latency through an empty chain SHALL be NUM_TILES cycles from ingress transfer to out_valid, one cycle per tile; throughput SHALL be one word per cycle.
REQ-020 The ALU SHALL compute PASS: d; ADD: d+imm modulo 2^DATA_WIDTH; XOR: d^imm; ACC: acc+d modulo 2^DATA_WIDTH, with acc updated to that value on pop; DROP: no output.
REQ-021 out_valid SHALL be high only when the last tile's head is valid and its opcode is not DROP; out_data SHALL be stable while out_valid is high and out_ready is low.
REQ-022 A cfg write SHALL take effect in the cycle after cfg_we and SHALL clear that tile's acc to 0; FIFO contents SHALL be untouched.
REQ-023 A cfg write coinciding with a pop at the same tile SHALL apply the old configuration to the popped word.

Reset
REQ-024 On reset all FIFOs SHALL empty, all acc registers SHALL become 0, and all opcodes SHALL become PASS with imm 0.
REQ-025 In the cycle after reset: in_ready=1, out_valid=0, out_data=0.
REQ-026 Reset mid-traffic SHALL discard all in-flight words; inputs sampled during reset SHALL be ignored.

Configuration
REQ-027 Macro CGRA_SAT_EN: when defined, ADD and ACC SHALL saturate at 2^DATA_WIDTH-1; when undefined, both SHALL wrap modulo 2^DATA_WIDTH.

Structure
REQ-028 Package cgra_pkg SHALL hold the opcode enum typedef and the opcode width constant.
REQ-029 Sub-module cgra_tile SHALL implement one FIFO, ALU, configuration register set and acc register; cgra_chain SHALL instantiate NUM_TILES copies in a generate loop.

Verification
REQ-030 With all tiles PASS, push 0x5A and hold out_ready=1 -> out_valid=1 with out_data=0x5A exactly 4 cycles after the transfer.
REQ-031 Configure tile0 ADD 0x10 and tile1 XOR 0xFF, then push 0x05 -> out_data=0xEA.
REQ-032 Configure tile0 ADD 0xF0, then push 0x20 -> out_data=0x10 without CGRA_SAT_EN, 0xFF with CGRA_SAT_EN.
REQ-033 Hold out_ready=0 and push 0..16 -> in_ready falls after 16 accepted words; then release out_ready -> 0..15 emerge in order and word 16 is accepted once in_ready returns.
REQ-034 Configure tile3 ACC and push 1,2,3 -> outputs 1,3,6; rewrite tile3 cfg, then push 4 -> output 4; configure tile2 DROP, then push 3 words -> out_valid stays 0.
REQ-035 Assert reset for 1 cycle with 8 words in flight -> the next cycle has out_valid=0 and in_ready=1, and a subsequent push of 0x33 emerges alone as 0x33.
